// File: rtl/nova_ddr_arb_pkg.sv
// Shared types for the two-requester DDR channel-A AXI4 arbiter.
package nova_ddr_arb_pkg;

  localparam int NUM_REQ       = 2;
  localparam int AX_ID_MAX_W   = 16;
  localparam int AX_ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  // Address-channel payload; id/addr sized for the widest configuration.
  typedef struct packed {
    logic [AX_ID_MAX_W-1:0]   id;
    logic [AX_ADDR_MAX_W-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } axi_ax_t;

  typedef enum logic {
    ADDR_IDLE = 1'b0,
    ADDR_BUSY = 1'b1
  } addr_state_e;

endpackage

// File: rtl/nova_ddr_rr_arb.sv
// Round-robin address-channel arbiter with a one-deep IDLE/BUSY output register.
module nova_ddr_rr_arb
  import nova_ddr_arb_pkg::*;
#(
  parameter int ID_W   = 16,
  parameter int ADDR_W = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0][ID_W-2:0]      req_id,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][7:0]           req_len,
  input  logic [NUM_REQ-1:0][2:0]           req_size,
  input  logic [NUM_REQ-1:0][1:0]           req_burst,
  input  logic                              allow,
  output logic [NUM_REQ-1:0]                ack,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [ID_W-1:0]                   m_id,
  output logic [ADDR_W-1:0]                 m_addr,
  output logic [7:0]                        m_len,
  output logic [2:0]                        m_size,
  output logic [1:0]                        m_burst
);

  addr_state_e state_q, state_d;
  axi_ax_t     ax_q, ax_d;
  logic        last_q, last_d;
  logic        win;

  // Winner selection, grant handshake and next-state.
  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    last_d  = last_q;
    ack     = '0;
    // When both request, the one that did not win last time goes next.
    if (req[0] && req[1]) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
    case (state_q)
      ADDR_IDLE: begin
        if (rst_n && allow && (|req)) begin
          ack[win]    = 1'b1;
          ax_d.id     = AX_ID_MAX_W'({win, req_id[win]});
          ax_d.addr   = AX_ADDR_MAX_W'(req_addr[win]);
          ax_d.len    = req_len[win];
          ax_d.size   = req_size[win];
          ax_d.burst  = req_burst[win];
          last_d      = win;
          state_d     = ADDR_BUSY;
        end else begin
          state_d = ADDR_IDLE;
        end
      end
      ADDR_BUSY: begin
        if (m_ready) begin
          state_d = ADDR_IDLE;
        end else begin
          state_d = ADDR_BUSY;
        end
      end
      default: state_d = ADDR_IDLE;
    endcase
  end

  // State, payload and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ADDR_IDLE;
      ax_q    <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      last_q  <= last_d;
    end
  end

  assign m_valid = (state_q == ADDR_BUSY);
  assign m_id    = ax_q.id[ID_W-1:0];
  assign m_addr  = ax_q.addr[ADDR_W-1:0];
  assign m_len   = ax_q.len;
  assign m_size  = ax_q.size;
  assign m_burst = ax_q.burst;

endmodule

// File: rtl/nova_ddr_axi_arb.sv
// Shares DDR channel A between two AXI4 masters: RR address arbitration,
// W beats ordered by AW grant order, responses routed by the prepended ID MSB.
module nova_ddr_axi_arb
  import nova_ddr_arb_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 16,
  parameter int WQ_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                s_awvalid,
  output logic [NUM_REQ-1:0]                s_awready,
  input  logic [NUM_REQ-1:0][ID_W-2:0]      s_awid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    s_awaddr,
  input  logic [NUM_REQ-1:0][7:0]           s_awlen,
  input  logic [NUM_REQ-1:0][2:0]           s_awsize,
  input  logic [NUM_REQ-1:0][1:0]           s_awburst,
  input  logic [NUM_REQ-1:0]                s_wvalid,
  input  logic [NUM_REQ-1:0]                s_wlast,
  output logic [NUM_REQ-1:0]                s_wready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    s_wdata,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0]  s_wstrb,
  output logic [NUM_REQ-1:0]                s_bvalid,
  output logic [NUM_REQ-1:0][ID_W-2:0]      s_bid,
  output logic [NUM_REQ-1:0][1:0]           s_bresp,
  input  logic [NUM_REQ-1:0]                s_bready,
  input  logic [NUM_REQ-1:0]                s_arvalid,
  output logic [NUM_REQ-1:0]                s_arready,
  input  logic [NUM_REQ-1:0][ID_W-2:0]      s_arid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    s_araddr,
  input  logic [NUM_REQ-1:0][7:0]           s_arlen,
  input  logic [NUM_REQ-1:0][2:0]           s_arsize,
  input  logic [NUM_REQ-1:0][1:0]           s_arburst,
  output logic [NUM_REQ-1:0]                s_rvalid,
  output logic [NUM_REQ-1:0][ID_W-2:0]      s_rid,
  output logic [NUM_REQ-1:0][DATA_W-1:0]    s_rdata,
  output logic [NUM_REQ-1:0][1:0]           s_rresp,
  output logic [NUM_REQ-1:0]                s_rlast,
  input  logic [NUM_REQ-1:0]                s_rready,
  output logic                              m_awvalid,
  output logic [ID_W-1:0]                   m_awid,
  output logic [ADDR_W-1:0]                 m_awaddr,
  output logic [7:0]                        m_awlen,
  output logic [2:0]                        m_awsize,
  output logic [1:0]                        m_awburst,
  input  logic                              m_awready,
  output logic                              m_wvalid,
  output logic [DATA_W-1:0]                 m_wdata,
  output logic [DATA_W/8-1:0]               m_wstrb,
  output logic                              m_wlast,
  input  logic                              m_wready,
  input  logic                              m_bvalid,
  input  logic [ID_W-1:0]                   m_bid,
  input  logic [1:0]                        m_bresp,
  output logic                              m_bready,
  output logic                              m_arvalid,
  output logic [ID_W-1:0]                   m_arid,
  output logic [ADDR_W-1:0]                 m_araddr,
  output logic [7:0]                        m_arlen,
  output logic [2:0]                        m_arsize,
  output logic [1:0]                        m_arburst,
  input  logic                              m_arready,
  input  logic                              m_rvalid,
  input  logic [ID_W-1:0]                   m_rid,
  input  logic [DATA_W-1:0]                 m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic                              m_rlast,
  output logic                              m_rready
);

  localparam int PW = $clog2(WQ_DEPTH);

  logic [WQ_DEPTH-1:0] wq_mem;
  logic [PW:0]         wq_wr, wq_rd;
  logic                wq_full, wq_empty, wq_push, wq_pop, head;
  logic                b_sel, r_sel;

  nova_ddr_rr_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W)) u_aw_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (s_awvalid),
    .req_id    (s_awid),
    .req_addr  (s_awaddr),
    .req_len   (s_awlen),
    .req_size  (s_awsize),
    .req_burst (s_awburst),
    .allow     (~wq_full),
    .ack       (s_awready),
    .m_valid   (m_awvalid),
    .m_ready   (m_awready),
    .m_id      (m_awid),
    .m_addr    (m_awaddr),
    .m_len     (m_awlen),
    .m_size    (m_awsize),
    .m_burst   (m_awburst)
  );

  nova_ddr_rr_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W)) u_ar_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (s_arvalid),
    .req_id    (s_arid),
    .req_addr  (s_araddr),
    .req_len   (s_arlen),
    .req_size  (s_arsize),
    .req_burst (s_arburst),
    .allow     (1'b1),
    .ack       (s_arready),
    .m_valid   (m_arvalid),
    .m_ready   (m_arready),
    .m_id      (m_arid),
    .m_addr    (m_araddr),
    .m_len     (m_arlen),
    .m_size    (m_arsize),
    .m_burst   (m_arburst)
  );

  // Full is derived from registered pointers only, so a same-cycle pop never enables a grant.
  assign wq_full  = (wq_wr[PW] != wq_rd[PW]) && (wq_wr[PW-1:0] == wq_rd[PW-1:0]);
  assign wq_empty = (wq_wr == wq_rd);
  assign wq_push  = |s_awready;
  assign head     = wq_mem[wq_rd[PW-1:0]];
  assign wq_pop   = m_wvalid && m_wready && s_wlast[head];

  // W-order FIFO: one entry per granted AW, holding the requester index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wq_mem <= '0;
      wq_wr  <= '0;
      wq_rd  <= '0;
    end else begin
      if (wq_push) begin
        wq_mem[wq_wr[PW-1:0]] <= s_awready[1];
        wq_wr                 <= wq_wr + (PW+1)'(1);
      end else begin
        wq_wr <= wq_wr;
      end
      if (wq_pop) begin
        wq_rd <= wq_rd + (PW+1)'(1);
      end else begin
        wq_rd <= wq_rd;
      end
    end
  end

  assign b_sel = m_bid[ID_W-1];
  assign r_sel = m_rid[ID_W-1];

  // W mux keyed by the FIFO head; B/R demux keyed by the ID MSB.
  always_comb begin
    s_wready = '0;
    s_bvalid = '0;
    s_rvalid = '0;
    if (!wq_empty) begin
      s_wready[head] = m_wready;
    end else begin
      s_wready = '0;
    end
    m_wvalid = !wq_empty && s_wvalid[head];
    m_wdata  = s_wdata[head];
    m_wstrb  = s_wstrb[head];
    m_wlast  = s_wlast[head];
    s_bvalid[b_sel] = m_bvalid;
    m_bready        = s_bready[b_sel];
    s_rvalid[r_sel] = m_rvalid;
    m_rready        = s_rready[r_sel];
    for (int i = 0; i < NUM_REQ; i++) begin
      s_bid[i]   = m_bid[ID_W-2:0];
      s_bresp[i] = m_bresp;
      s_rid[i]   = m_rid[ID_W-2:0];
      s_rdata[i] = m_rdata;
      s_rresp[i] = m_rresp;
      s_rlast[i] = m_rlast;
    end
  end

endmodule

// File: tb/tb_nova_ddr_axi_arb.sv
// Directed + randomized bench for nova_ddr_axi_arb against a transaction-level model.
module tb_nova_ddr_axi_arb;
  import nova_ddr_arb_pkg::*;

  localparam int ID_W = 16, ADDR_W = 64, DATA_W = 512, SW = 64, WQ_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [1:0] s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [1:0][ID_W-2:0] s_awid, s_bid, s_arid, s_rid;
  logic [1:0][ADDR_W-1:0] s_awaddr, s_araddr;
  logic [1:0][7:0] s_awlen, s_arlen;
  logic [1:0][2:0] s_awsize, s_arsize;
  logic [1:0][1:0] s_awburst, s_arburst, s_bresp, s_rresp;
  logic [1:0][DATA_W-1:0] s_wdata, s_rdata;
  logic [1:0][SW-1:0] s_wstrb;
  logic m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [ID_W-1:0] m_awid, m_bid, m_arid, m_rid;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize;
  logic [1:0] m_awburst, m_arburst, m_bresp, m_rresp;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;

  int checks = 0, failures = 0;

  nova_ddr_axi_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .WQ_DEPTH(WQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rready(s_rready),
    .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [1:0] oh(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [DATA_W-1:0] rnd512();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Model state: W-order queue of requester indices, AR round-robin pointer.
  logic wq_model[$];
  logic last_ar, ar_busy, w;
  logic [ID_W-1:0] exp_arid;
  logic [DATA_W-1:0] dat [2][4];
  logic [DATA_W-1:0] rdat;
  logic [ADDR_W-1:0] addr0;
  int cnt[2];
  int beat[2];
  int acc, rb, lim;
  logic tog, mb;

  initial begin
    rst_n = 1'b0;
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_wdata = '0; s_wstrb = '0;
    m_awready = 1'b0; m_wready = 1'b1; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_awvalid", m_awvalid, 1'b0);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_awready", s_awready, 2'b00);
    chk("rst_wready", s_wready, 2'b00);
    chk("rst_wvalid", m_wvalid, 1'b0);
    m_wready = 1'b0;

    // Single write from req0, id 0x12, 4 beats.
    addr0 = {$urandom(), $urandom()};
    s_awid[0] = 15'h12; s_awaddr[0] = addr0; s_awlen[0] = 8'd3; s_awsize[0] = 3'd6;
    s_awburst[0] = BURST_INCR; s_awvalid = 2'b01;
    #1; chk("aw1_ready", s_awready, 2'b01);
    wq_model.push_back(1'b0);
    tick(); s_awvalid = 2'b00; #1;
    chk("aw1_mvalid", m_awvalid, 1'b1);
    chk("aw1_mid", m_awid, 16'h0012);
    chk("aw1_addr", m_awaddr, addr0);
    chk("aw1_len", m_awlen, 8'd3);
    chk("aw1_burst", m_awburst, BURST_INCR);
    m_awready = 1'b1;
    tick(); #1;
    chk("aw1_idle", m_awvalid, 1'b0);
    m_wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      dat[0][b] = rnd512();
      s_wdata[0] = dat[0][b]; s_wvalid = 2'b01; s_wlast = (b == 3) ? 2'b01 : 2'b00;
      #1;
      chk("w1_valid", m_wvalid, 1'b1);
      chk("w1_data", m_wdata, dat[0][b]);
      chk("w1_last", m_wlast, (b == 3));
      chk("w1_ready", s_wready, 2'b01);
      tick();
    end
    void'(wq_model.pop_front());
    s_wvalid = 2'b00; s_wlast = 2'b00; #1;
    chk("w1_drained", s_wready, 2'b00);
    m_bvalid = 1'b1; m_bid = 16'h0012; m_bresp = 2'b00; s_bready = 2'b01; #1;
    chk("b1_valid", s_bvalid, 2'b01);
    chk("b1_id", s_bid[0], 15'h12);
    chk("b1_mready", m_bready, 1'b1);
    s_bready = 2'b10; #1;
    chk("b1_mready_other", m_bready, 1'b0);
    // Randomized B routing.
    for (int k = 0; k < 8; k++) begin
      m_bid = 16'($urandom()); m_bresp = 2'($urandom()); s_bready = 2'($urandom_range(0, 3));
      #1;
      chk("b_rand_valid", s_bvalid, oh(m_bid[15]));
      chk("b_rand_ready", m_bready, s_bready[m_bid[15]]);
      chk("b_rand_id", s_bid[m_bid[15]], m_bid[14:0]);
      chk("b_rand_resp", s_bresp[m_bid[15]], m_bresp);
    end
    m_bvalid = 1'b0; s_bready = 2'b00;
    tick();

    // Both requesters continuously request AR: grants alternate, starting with req0.
    last_ar = 1'b1; cnt[0] = 0; cnt[1] = 0;
    m_arready = 1'b1; s_arvalid = 2'b11;
    for (int g = 0; g < 12; g++) begin
      s_arid[0] = 15'($urandom()); s_arid[1] = 15'($urandom());
      s_araddr[0] = {$urandom(), $urandom()}; s_araddr[1] = {$urandom(), $urandom()};
      #1;
      w = ~last_ar;
      chk("ar_alt_ready", s_arready, oh(w));
      tick();
      chk("ar_alt_mvalid", m_arvalid, 1'b1);
      chk("ar_alt_id", m_arid, {w, s_arid[w]});
      chk("ar_alt_addr", m_araddr, s_araddr[w]);
      chk("ar_alt_busy_ready", s_arready, 2'b00);
      last_ar = w; cnt[w]++;
      tick();
    end
    chk("ar_alt_cnt0", cnt[0], 6);
    chk("ar_alt_cnt1", cnt[1], 6);

    // Randomized AR requests with random m_arready stalls.
    ar_busy = 1'b0; exp_arid = '0;
    for (int k = 0; k < 40; k++) begin
      s_arvalid = 2'($urandom_range(0, 3)); m_arready = 1'($urandom());
      s_arid[0] = 15'($urandom()); s_arid[1] = 15'($urandom());
      #1;
      if (ar_busy) begin
        chk("ar_rnd_busy_ready", s_arready, 2'b00);
        chk("ar_rnd_mvalid", m_arvalid, 1'b1);
        chk("ar_rnd_id", m_arid, exp_arid);
        if (m_arready) ar_busy = 1'b0;
      end else begin
        chk("ar_rnd_mvalid_idle", m_arvalid, 1'b0);
        if (s_arvalid == 2'b00) begin
          chk("ar_rnd_noreq", s_arready, 2'b00);
        end else begin
          w = (s_arvalid == 2'b11) ? ~last_ar : s_arvalid[1];
          chk("ar_rnd_ready", s_arready, oh(w));
          exp_arid = {w, s_arid[w]}; last_ar = w; ar_busy = 1'b1;
        end
      end
      tick();
    end
    s_arvalid = 2'b00; m_arready = 1'b1;
    tick(); tick();

    // req1 AW then req0 AW; req0 data is presented first but must wait.
    m_awready = 1'b1;
    s_awid[1] = 15'($urandom()); s_awvalid = 2'b10; #1;
    chk("ord_aw1_ready", s_awready, 2'b10);
    wq_model.push_back(1'b1);
    tick(); s_awvalid = 2'b00; tick();
    s_awid[0] = 15'($urandom()); s_awvalid = 2'b01; #1;
    chk("ord_aw0_ready", s_awready, 2'b01);
    wq_model.push_back(1'b0);
    tick(); s_awvalid = 2'b00; tick();
    for (int r = 0; r < 2; r++) for (int b = 0; b < 4; b++) dat[r][b] = rnd512();
    beat[0] = 0; beat[1] = 0;
    s_wdata[0] = dat[0][0]; s_wlast = 2'b00; s_wvalid = 2'b01; m_wready = 1'b1; #1;
    chk("ord_hold_req0", s_wready, 2'b10);
    chk("ord_hold_mvalid", m_wvalid, 1'b0);
    tick();
    s_wvalid = 2'b11; lim = 0;
    while (wq_model.size() > 0 && lim < 60) begin
      m_wready = 1'($urandom());
      for (int r = 0; r < 2; r++) begin
        s_wdata[r] = dat[r][beat[r] & 3];
        s_wlast[r] = (beat[r] == 3);
        s_wvalid[r] = (beat[r] < 4);
      end
      w = wq_model[0];
      #1;
      chk("ord_wready", s_wready, m_wready ? oh(w) : 2'b00);
      chk("ord_wdata", m_wdata, dat[w][beat[w]]);
      chk("ord_wlast", m_wlast, (beat[w] == 3));
      tick();
      if (m_wready) begin
        if (beat[w] == 3) void'(wq_model.pop_front());
        beat[w]++;
      end
      lim++;
    end
    chk("ord_complete", wq_model.size(), 0);
    s_wvalid = 2'b00; s_wlast = 2'b00; m_wready = 1'b1;
    tick();

    // W FIFO fills at WQ_DEPTH entries; further AWs wait for a wlast pop.
    acc = 0; s_awvalid = 2'b01; m_awready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      #1;
      if (s_awready != 2'b00) begin
        acc++;
        wq_model.push_back(1'b0);
      end
      tick();
    end
    chk("full_accepts", acc, WQ_DEPTH);
    #1; chk("full_no_grant", s_awready, 2'b00);
    s_wvalid = 2'b01; s_wlast = 2'b01; s_wdata[0] = rnd512();
    tick();
    void'(wq_model.pop_front());
    s_wvalid = 2'b00; #1;
    chk("full_pop_regrant", s_awready, 2'b01);
    wq_model.push_back(1'b0);
    tick();
    s_awvalid = 2'b00; tick();
    for (int k = 0; k < WQ_DEPTH; k++) begin
      s_wvalid = 2'b01; s_wlast = 2'b01; #1;
      chk("full_drain_ready", s_wready, 2'b01);
      tick();
      void'(wq_model.pop_front());
    end
    s_wvalid = 2'b00; s_wlast = 2'b00; #1;
    chk("full_empty", s_wready, 2'b00);

    // Read burst of 8 to req1 with s_rready[1] toggling.
    m_rvalid = 1'b1; m_rid = {1'b1, 15'($urandom())}; m_rresp = 2'b00;
    rb = 0; tog = 1'b1; lim = 0;
    while (rb < 8 && lim < 40) begin
      rdat = rnd512();
      m_rdata = rdat; m_rlast = (rb == 7);
      s_rready = {tog, 1'($urandom())};
      #1;
      chk("rd_valid", s_rvalid, 2'b10);
      chk("rd_mready", m_rready, tog);
      chk("rd_data", s_rdata[1], rdat);
      chk("rd_id", s_rid[1], m_rid[14:0]);
      chk("rd_last", s_rlast[1], (rb == 7));
      tick();
      if (tog) rb++;
      tog = ~tog; lim++;
    end
    chk("rd_beats", rb, 8);
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
    tick();

    // Reset during a BUSY AW with two FIFO entries.
    m_awready = 1'b1; s_awvalid = 2'b01; tick(); s_awvalid = 2'b00; tick();
    m_awready = 1'b0; s_awvalid = 2'b10; tick(); s_awvalid = 2'b00; tick();
    #1; chk("rstmid_busy", m_awvalid, 1'b1);
    mb = m_awid[15];
    chk("rstmid_busy_req1", mb, 1'b1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    s_wvalid = 2'b11; m_wready = 1'b1; #1;
    chk("rstmid_awvalid", m_awvalid, 1'b0);
    chk("rstmid_wready", s_wready, 2'b00);
    chk("rstmid_wvalid", m_wvalid, 1'b0);
    s_wvalid = 2'b00; s_awvalid = 2'b11; #1;
    chk("rstmid_first_grant", s_awready, 2'b01);
    tick(); s_awvalid = 2'b00; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
